// File: rtl/rf_pkg.sv
// Shared constants and helpers for the RV32 integer register file.
// Holds default sizes, the hardwired-zero index and packed-port slicing.
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ZERO_REG = 0;

    // Low bit of lane k in a packed port whose lanes are w bits wide.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on load writeback.
// Register 0 never becomes pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_rd,
    input  logic            wl_en,
    input  logic [AW-1:0]   wl_id,
    output logic [NREG-1:0] pending,
    output logic            any_busy
);

    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] pending_nxt_s;
    logic            any_busy_r;

    // Next pending state: a new issue beats a completing writeback to the same register.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 0; i < NREG; i++) begin
            if (i == ZERO_REG) begin
                pending_nxt_s[i] = 1'b0;
            end else if (ld_issue && (ld_rd == AW'(i))) begin
                pending_nxt_s[i] = 1'b1;
            end else if (wl_en && (wl_id == AW'(i))) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
    end

    // Pending vector and its OR; reset drops any outstanding loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= '0;
            any_busy_r <= 1'b0;
        end else begin
            pending_r  <= pending_nxt_s;
            any_busy_r <= |pending_nxt_s;
        end
    end

    assign pending  = pending_r;
    assign any_busy = any_busy_r;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with NRD combinational read ports, ALU and load write ports,
// optional write-to-read bypass and a pending-load scoreboard for decode stalls.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int  XLEN   = XLEN_DEF,
    parameter int  NREG   = NREG_DEF,
    parameter int  NRD    = 2,
    parameter bit  BYPASS = 1'b1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_id,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wa_en,
    input  logic [AW-1:0]     wa_id,
    input  logic [XLEN-1:0]   wa_data,
    input  logic              wl_en,
    input  logic [AW-1:0]     wl_id,
    input  logic [XLEN-1:0]   wl_data,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_rd,
    output logic              any_busy
);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] pending_s;
    logic            wa_hit_s;
    logic            wl_hit_s;

    assign wa_hit_s = wa_en && (wa_id != AW'(ZERO_REG));
    assign wl_hit_s = wl_en && (wl_id != AW'(ZERO_REG));

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_issue (ld_issue),
        .ld_rd    (ld_rd),
        .wl_en    (wl_en),
        .wl_id    (wl_id),
        .pending  (pending_s),
        .any_busy (any_busy)
    );

    // Register storage; port A is written last so it wins a same-id conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (wl_hit_s) begin
                regs_r[wl_id] <= wl_data;
            end
            if (wa_hit_s) begin
                regs_r[wa_id] <= wa_data;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   id_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;

        assign id_s = rd_id[slice_lo(k, AW) +: AW];

        // Read mux: reset forces zero, else bypass in age order, else stored value.
        always_comb begin
            data_s = regs_r[id_s];
            busy_s = pending_s[id_s];
            if (!rst_n) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if (BYPASS) begin
                if (wa_hit_s && (wa_id == id_s)) begin
                    data_s = wa_data;
                end else if (wl_hit_s && (wl_id == id_s)) begin
                    data_s = wl_data;
                end else begin
                    data_s = regs_r[id_s];
                end
                if (wl_en && (wl_id == id_s)) begin
                    busy_s = 1'b0;
                end else begin
                    busy_s = pending_s[id_s];
                end
            end else begin
                data_s = regs_r[id_s];
                busy_s = pending_s[id_s];
            end
        end

        assign rd_data[slice_lo(k, XLEN) +: XLEN] = data_s;
        assign rd_busy[k]                         = busy_s;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a default bypassing instance and a 64-bit, 16-entry,
// 3-read-port instance without bypass share the same stimulus.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rid0, rid1;
    logic        wa_en, wl_en, ld_issue;
    logic [4:0]  wa_id, wl_id, ld_rd;
    logic [31:0] wa_data, wl_data;

    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic         any_busy_b;
    logic [191:0] rd_data_n;
    logic [2:0]   rd_busy_n;
    logic         any_busy_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1'b1)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_id    ({rid1, rid0}),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b),
        .wa_en    (wa_en),
        .wa_id    (wa_id),
        .wa_data  (wa_data),
        .wl_en    (wl_en),
        .wl_id    (wl_id),
        .wl_data  (wl_data),
        .ld_issue (ld_issue),
        .ld_rd    (ld_rd),
        .any_busy (any_busy_b)
    );

    reg_file_sb #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(1'b0)) dut_n (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_id    ({rid1[3:0], rid1[3:0], rid0[3:0]}),
        .rd_data  (rd_data_n),
        .rd_busy  (rd_busy_n),
        .wa_en    (wa_en),
        .wa_id    (wa_id[3:0]),
        .wa_data  ({wa_data, wa_data}),
        .wl_en    (wl_en),
        .wl_id    (wl_id[3:0]),
        .wl_data  ({wl_data, wl_data}),
        .ld_issue (ld_issue),
        .ld_rd    (ld_rd[3:0]),
        .any_busy (any_busy_n)
    );

    function automatic logic [63:0] dup(input logic [31:0] v);
        return {v, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wa_en    = 1'b0;
        wl_en    = 1'b0;
        ld_issue = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rid0 = 5'd0; rid1 = 5'd0;
        wa_id = 5'd0; wl_id = 5'd0; ld_rd = 5'd0;
        wa_data = 32'h0; wl_data = 32'h0;
        idle();
        #2;
        chk("rst_data_b", {32'h0, rd_data_b[31:0]}, 64'h0);
        chk("rst_any_b", {63'h0, any_busy_b}, 64'h0);
        chk("rst_any_n", {63'h0, any_busy_n}, 64'h0);
        #10 rst_n = 1'b1;
        tick();

        // x0 protection
        wa_en = 1'b1; wa_id = 5'd0; wa_data = 32'hFFFFFFFF;
        ld_issue = 1'b1; ld_rd = 5'd0; rid0 = 5'd0;
        #1;
        chk("x0_byp_b", {32'h0, rd_data_b[31:0]}, 64'h0);
        tick(); idle(); #1;
        chk("x0_data_b", {32'h0, rd_data_b[31:0]}, 64'h0);
        chk("x0_data_n", rd_data_n[63:0], 64'h0);
        chk("x0_busy_b", {62'h0, rd_busy_b}, 64'h0);
        chk("x0_any_b", {63'h0, any_busy_b}, 64'h0);
        chk("x0_any_n", {63'h0, any_busy_n}, 64'h0);

        // Dual write to x7: port A wins
        wa_en = 1'b1; wa_id = 5'd7; wa_data = 32'h11111111;
        wl_en = 1'b1; wl_id = 5'd7; wl_data = 32'h22222222;
        rid1 = 5'd7;
        #1;
        chk("dual_byp_b", {32'h0, rd_data_b[63:32]}, 64'h11111111);
        chk("dual_old_n", rd_data_n[127:64], 64'h0);
        tick(); idle(); #1;
        chk("dual_b", {32'h0, rd_data_b[63:32]}, 64'h11111111);
        chk("dual_n", rd_data_n[127:64], dup(32'h11111111));
        chk("dual_n_p2", rd_data_n[191:128], dup(32'h11111111));

        // Bypass versus stored read of x3
        wa_en = 1'b1; wa_id = 5'd3; wa_data = 32'hA5A5A5A5; rid1 = 5'd3;
        #1;
        chk("byp_b", {32'h0, rd_data_b[63:32]}, 64'hA5A5A5A5);
        chk("nobyp_old_n", rd_data_n[127:64], 64'h0);
        tick(); idle(); #1;
        chk("nobyp_new_n", rd_data_n[127:64], dup(32'hA5A5A5A5));

        // Scoreboard on x10, pending for 3 cycles
        ld_issue = 1'b1; ld_rd = 5'd10; rid0 = 5'd10;
        #1;
        chk("sb_pre_b", {63'h0, rd_busy_b[0]}, 64'h0);
        tick(); idle();
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("sb_busy_b", {63'h0, rd_busy_b[0]}, 64'h1);
            chk("sb_busy_n", {63'h0, rd_busy_n[0]}, 64'h1);
            chk("sb_any_b", {63'h0, any_busy_b}, 64'h1);
            if (c == 2) begin
                wa_en = 1'b1; wa_id = 5'd10; wa_data = 32'h99;
            end
            tick(); idle();
        end
        wl_en = 1'b1; wl_id = 5'd10; wl_data = 32'h1234;
        #1;
        chk("sb_done_busy_b", {63'h0, rd_busy_b[0]}, 64'h0);
        chk("sb_done_data_b", {32'h0, rd_data_b[31:0]}, 64'h1234);
        chk("sb_done_busy_n", {63'h0, rd_busy_n[0]}, 64'h1);
        chk("sb_done_any_b", {63'h0, any_busy_b}, 64'h1);
        tick(); idle(); #1;
        chk("sb_after_busy_n", {63'h0, rd_busy_n[0]}, 64'h0);
        chk("sb_after_data_n", rd_data_n[63:0], dup(32'h1234));
        chk("sb_after_any_b", {63'h0, any_busy_b}, 64'h0);
        chk("sb_after_any_n", {63'h0, any_busy_n}, 64'h0);

        // Issue/complete collision on x12
        ld_issue = 1'b1; ld_rd = 5'd12; rid0 = 5'd12;
        tick(); idle();
        ld_issue = 1'b1; ld_rd = 5'd12;
        wl_en = 1'b1; wl_id = 5'd12; wl_data = 32'hCAFEF00D;
        #1;
        chk("col_byp_busy_b", {63'h0, rd_busy_b[0]}, 64'h0);
        chk("col_byp_data_b", {32'h0, rd_data_b[31:0]}, 64'hCAFEF00D);
        tick(); idle(); #1;
        chk("col_busy_b", {63'h0, rd_busy_b[0]}, 64'h1);
        chk("col_busy_n", {63'h0, rd_busy_n[0]}, 64'h1);
        chk("col_data_b", {32'h0, rd_data_b[31:0]}, 64'hCAFEF00D);
        chk("col_data_n", rd_data_n[63:0], dup(32'hCAFEF00D));
        wl_en = 1'b1; wl_id = 5'd12; wl_data = 32'h55;
        tick(); idle(); #1;
        chk("col_clear_any_b", {63'h0, any_busy_b}, 64'h0);
        chk("col_clear_data_n", rd_data_n[63:0], dup(32'h55));

        // Asynchronous reset mid-cycle with a load outstanding on x9
        wa_en = 1'b1; wa_id = 5'd5; wa_data = 32'hDEADBEEF;
        ld_issue = 1'b1; ld_rd = 5'd9;
        tick(); idle();
        rid0 = 5'd5; rid1 = 5'd9;
        #1;
        chk("pre_rst_data_b", {32'h0, rd_data_b[31:0]}, 64'hDEADBEEF);
        chk("pre_rst_any_n", {63'h0, any_busy_n}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data_b", {32'h0, rd_data_b[31:0]}, 64'h0);
        chk("mid_rst_data_n", rd_data_n[63:0], 64'h0);
        chk("mid_rst_busy_b", {62'h0, rd_busy_b}, 64'h0);
        chk("mid_rst_any_b", {63'h0, any_busy_b}, 64'h0);
        chk("mid_rst_any_n", {63'h0, any_busy_n}, 64'h0);
        #2 rst_n = 1'b1;
        tick();
        wl_en = 1'b1; wl_id = 5'd9; wl_data = 32'h77;
        tick(); idle(); #1;
        chk("post_rst_wl_b", {32'h0, rd_data_b[63:32]}, 64'h77);
        chk("post_rst_wl_n", rd_data_n[127:64], dup(32'h77));
        chk("post_rst_busy_b", {62'h0, rd_busy_b}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
